dma_streamer: RTL and testbench
===============================

DMA_STREAMER -- requirements
Module: dma_streamer

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 8: the maximum number of issued-but-unfinished bursts, legal range 1..15.
REQ-002 SHALL have parameter BEAT_BYTES, default 4: the AXI data bus width in bytes; only the value 4 is legal, so each beat carries 4 bytes and size = 2.
REQ-003 SHALL have a single clock and a reset that is synchronous and active-low.
REQ-004 clk  in  1  system clock; all state is updated on its rising edge.
REQ-005 rstn  in  1  synchronous, active-low reset.
REQ-006 dma_active_i  in  1  run enable from the DMA FSM; low means abort or idle.
REQ-007 start_i  in  1  single-cycle request to load a descriptor.
REQ-008 desc_addr_i  in  32  start byte address of the descriptor.
REQ-009 desc_bytes_i  in  32  total bytes to transfer.
REQ-010 max_alen_i  in  8  cap on the AXI length field (beats - 1).
REQ-011 dma_stream_req_o  out  s_dma_stream_req_t  {valid, addr[31:0], alen[7:0], size[2:0]} sent to the AXI interface block.
REQ-012 dma_stream_resp_i  in  s_dma_stream_resp_t  {ready, finish} returned from the AXI interface block.
REQ-013 busy_o  out  1  high whenever the state is not IDLE.
REQ-014 done_o  out  1  one-cycle pulse when the descriptor completes.
REQ-015 cfg_err_o  out  1  one-cycle pulse when a descriptor is rejected.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE and DRAIN.
REQ-017 IDLE SHALL behave as follows:
- start_i && dma_active_i with desc_addr_i[1:0]==0, desc_bytes_i[1:0]==0 and desc_bytes_i!=0: load addr_ff and beats_left_ff = desc_bytes_i>>2, then go to ISSUE.
- Any other start_i (misaligned address, misaligned length, or zero length): pulse cfg_err_o in the next cycle and stay in IDLE.
REQ-018 Burst size SHALL be computed combinationally in ISSUE:
- beats = min(beats_left_ff, max_alen_i+1, (4096 - addr_ff[11:0])>>2).
- All arithmetic is 13-bit unsigned, so max_alen_i=255 yields 256 beats.
REQ-019 In ISSUE the block SHALL drive valid=1 when outstanding_ff < MAX_OUTSTANDING, with addr=addr_ff, alen=beats-1, size=2.
REQ-020 Handshake rule: once valid is asserted, valid, addr and alen SHALL be held stable until the cycle in which ready=1.
REQ-021 On a handshake the block SHALL do all of the following:
- addr_ff += beats*4.
- beats_left_ff -= beats.
- outstanding_ff += 1.
- If beats_left_ff becomes 0, go to DRAIN; otherwise present the next burst with valid high in the following cycle (back-to-back issue).
REQ-022 First valid SHALL assert exactly one cycle after the start_i acceptance cycle.
REQ-023 Each finish=1 cycle SHALL decrement outstanding_ff.
REQ-024 A handshake and a finish in the same cycle SHALL leave outstanding_ff unchanged.
REQ-025 A finish while outstanding_ff==0 SHALL be ignored.
REQ-026 When outstanding_ff==MAX_OUTSTANDING, valid SHALL deassert; it reasserts the cycle after a finish.
REQ-027 DRAIN SHALL go to IDLE and pulse done_o in the cycle after outstanding_ff reaches 0.
REQ-028 Abort: dma_active_i low in any state SHALL, at the next edge, force IDLE and clear all counters; done_o is not pulsed and valid is low from that edge.
REQ-029 start_i outside IDLE SHALL be ignored.
REQ-030 A burst SHALL never cross a 4 KB boundary, and no burst SHALL have alen above max_alen_i.

Reset
REQ-031 While rstn==0 at a clock edge, the block SHALL enter IDLE and clear addr_ff, beats_left_ff and outstanding_ff.
REQ-032 Outputs during reset SHALL be: valid=0, addr=0, alen=0, size=0, busy_o=0, done_o=0, cfg_err_o=0.
REQ-033 Reset asserted mid-burst SHALL discard all state with no done_o pulse.
REQ-034 Reset SHALL have no asynchronous path.

Structure
REQ-035 dma_pkg SHALL hold the following, shared with the AXI interface block:
- s_dma_stream_req_t and s_dma_stream_resp_t.
- The DMA_4KB constant.
- The e_dma_stream_st_t state enum.
REQ-036 The min-of-three burst computation SHALL be a combinational sub-module named dma_burst_calc; all state stays in dma_streamer.

Verification
REQ-037 Scenario: addr=0x1000, bytes=64, max_alen=15, ready tied to 1 -> one burst: addr 0x1000, alen 15; after a single finish, done_o pulses.
REQ-038 Scenario: addr=0x0FF0, bytes=64, max_alen=255 -> burst 1: 0x0FF0, alen 3; burst 2: 0x1000, alen 11.
REQ-039 Scenario: addr=0x2000, bytes=4096, max_alen=7, MAX_OUTSTANDING=8, finish withheld -> 8 bursts issue, then valid stays low; one finish leads to the 9th burst the next cycle.
REQ-040 Scenario: addr=0x3002 (or bytes=0), start -> cfg_err_o pulses once, busy_o stays 0, valid is never asserted.
REQ-041 Scenario: ready held low for 5 cycles -> addr and alen are stable for all 5 cycles; a simultaneous handshake and finish leaves outstanding unchanged.
REQ-042 Scenario: dma_active_i dropped mid-ISSUE with 3 outstanding -> next cycle IDLE, valid=0, no done_o pulse; a new start then works from a clean state.

Source files
------------

// File: rtl/dma_pkg.sv
// Types and constants shared between the DMA streamer and the AXI interface block.
package dma_pkg;

    localparam int unsigned DMA_4KB = 4096;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [7:0]  alen;
        logic [2:0]  size;
    } s_dma_stream_req_t;

    typedef struct packed {
        logic ready;
        logic finish;
    } s_dma_stream_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } e_dma_stream_st_t;

endpackage

// File: rtl/dma_burst_calc.sv
// Burst length in beats: min of beats remaining, the alen cap and the room left in the 4 KB page.
module dma_burst_calc
    import dma_pkg::*;
(
    input  logic [29:0] beats_left,
    input  logic [11:0] addr_lo,
    input  logic [7:0]  max_alen,
    output logic [12:0] beats
);

    logic [12:0] left_beats;
    logic [12:0] cap_beats;
    logic [12:0] page_beats;

    always_comb begin
        left_beats = (beats_left > 30'(DMA_4KB)) ? 13'(DMA_4KB) : 13'(beats_left);
        cap_beats  = 13'(max_alen) + 13'd1;
        page_beats = (13'(DMA_4KB) - 13'(addr_lo)) >> 2;
        beats      = left_beats;
        if (cap_beats < beats) begin
            beats = cap_beats;
        end
        if (page_beats < beats) begin
            beats = page_beats;
        end
    end

endmodule

// File: rtl/dma_streamer.sv
// Splits a descriptor into 4 KB-safe AXI bursts and tracks outstanding bursts until all finish.
module dma_streamer
    import dma_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned BEAT_BYTES      = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               dma_active_i,
    input  logic               start_i,
    input  logic [31:0]        desc_addr_i,
    input  logic [31:0]        desc_bytes_i,
    input  logic [7:0]         max_alen_i,
    output s_dma_stream_req_t  dma_stream_req_o,
    input  s_dma_stream_resp_t dma_stream_resp_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               cfg_err_o
);

    localparam int unsigned OUT_W     = 4;
    localparam logic [2:0]  BEAT_SIZE = 3'($clog2(BEAT_BYTES));

    e_dma_stream_st_t state_ff, state_nxt;
    logic [31:0]      addr_ff, addr_nxt;
    logic [29:0]      beats_left_ff, beats_left_nxt;
    logic [OUT_W-1:0] outstanding_ff, outstanding_nxt;
    logic             done_ff, done_nxt;
    logic             cfg_err_ff, cfg_err_nxt;
    logic             busy_ff;

    logic [12:0]      burst_beats;
    logic             can_issue;
    logic             handshake;
    logic             finish_ok;
    logic             desc_ok;

    dma_burst_calc u_burst_calc (
        .beats_left (beats_left_ff),
        .addr_lo    (addr_ff[11:0]),
        .max_alen   (max_alen_i),
        .beats      (burst_beats)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_ff       <= ST_IDLE;
            addr_ff        <= '0;
            beats_left_ff  <= '0;
            outstanding_ff <= '0;
            done_ff        <= 1'b0;
            cfg_err_ff     <= 1'b0;
            busy_ff        <= 1'b0;
        end else begin
            state_ff       <= state_nxt;
            addr_ff        <= addr_nxt;
            beats_left_ff  <= beats_left_nxt;
            outstanding_ff <= outstanding_nxt;
            done_ff        <= done_nxt;
            cfg_err_ff     <= cfg_err_nxt;
            busy_ff        <= (state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        state_nxt        = state_ff;
        addr_nxt         = addr_ff;
        beats_left_nxt   = beats_left_ff;
        outstanding_nxt  = outstanding_ff;
        done_nxt         = 1'b0;
        cfg_err_nxt      = 1'b0;
        dma_stream_req_o = '0;

        can_issue = (outstanding_ff < OUT_W'(MAX_OUTSTANDING));
        handshake = (state_ff == ST_ISSUE) && can_issue && dma_stream_resp_i.ready;
        finish_ok = dma_stream_resp_i.finish && (outstanding_ff != '0);
        desc_ok   = (desc_addr_i[1:0] == 2'b00) && (desc_bytes_i[1:0] == 2'b00)
                    && (desc_bytes_i != '0);

        unique case (state_ff)
            ST_IDLE: begin
                if (start_i && dma_active_i) begin
                    if (desc_ok) begin
                        addr_nxt       = desc_addr_i;
                        beats_left_nxt = desc_bytes_i[31:2];
                        state_nxt      = ST_ISSUE;
                    end else begin
                        cfg_err_nxt = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                dma_stream_req_o.valid = can_issue;
                dma_stream_req_o.addr  = addr_ff;
                dma_stream_req_o.alen  = 8'(burst_beats - 13'd1);
                dma_stream_req_o.size  = BEAT_SIZE;
                if (handshake) begin
                    addr_nxt       = addr_ff + (32'(burst_beats) << 2);
                    beats_left_nxt = beats_left_ff - 30'(burst_beats);
                    if (beats_left_ff == 30'(burst_beats)) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (outstanding_ff == '0) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Simultaneous issue and finish cancel out.
        unique case ({handshake, finish_ok})
            2'b10:   outstanding_nxt = outstanding_ff + OUT_W'(1);
            2'b01:   outstanding_nxt = outstanding_ff - OUT_W'(1);
            default: outstanding_nxt = outstanding_ff;
        endcase

        // Abort wins over everything and discards the descriptor silently.
        if (!dma_active_i) begin
            state_nxt       = ST_IDLE;
            addr_nxt        = '0;
            beats_left_nxt  = '0;
            outstanding_nxt = '0;
            done_nxt        = 1'b0;
            cfg_err_nxt     = 1'b0;
        end
    end

    assign busy_o    = busy_ff;
    assign done_o    = done_ff;
    assign cfg_err_o = cfg_err_ff;

endmodule

// File: tb/tb_dma_streamer.sv
// Self-checking bench for dma_streamer: descriptor table, directed corner sequences, random descriptors.
module tb_dma_streamer;
    import dma_pkg::*;

    localparam int MAXO = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  alen;
    } burst_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] bytes;
        logic [7:0]  max_alen;
        bit          exp_err;
        int          exp_n;
    } vec_t;

    logic               clk = 1'b0;
    logic               rstn;
    logic               dma_active;
    logic               start;
    logic [31:0]        desc_addr;
    logic [31:0]        desc_bytes;
    logic [7:0]         max_alen;
    s_dma_stream_req_t  req;
    s_dma_stream_resp_t resp;
    logic               busy, done, cfg_err;

    int     nvec = 0;
    int     nerr = 0;
    int     outs_model = 0;
    int     done_cnt = 0;
    int     cfg_cnt = 0;
    burst_t got_q[$];
    burst_t exp_q[$];

    logic        pend = 1'b0;
    logic [31:0] pend_addr;
    logic [7:0]  pend_alen;
    logic        mon_hs, mon_fin;
    int          end_off;

    vec_t tbl[9];

    always #5 clk = ~clk;

    dma_streamer #(.MAX_OUTSTANDING(MAXO), .BEAT_BYTES(4)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .dma_active_i      (dma_active),
        .start_i           (start),
        .desc_addr_i       (desc_addr),
        .desc_bytes_i      (desc_bytes),
        .max_alen_i        (max_alen),
        .dma_stream_req_o  (req),
        .dma_stream_resp_i (resp),
        .busy_o            (busy),
        .done_o            (done),
        .cfg_err_o         (cfg_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus monitor: records accepted bursts, checks hold-while-stalled and burst legality.
    always @(posedge clk) begin
        if (done)    done_cnt++;
        if (cfg_err) cfg_cnt++;
        if (!rstn || !dma_active) begin
            outs_model = 0;
            pend       = 1'b0;
        end else begin
            if (pend) begin
                chk("hold_valid", 64'(req.valid), 64'd1);
                chk("hold_addr",  64'(req.addr),  64'(pend_addr));
                chk("hold_alen",  64'(req.alen),  64'(pend_alen));
            end
            mon_hs  = req.valid && resp.ready;
            mon_fin = resp.finish && (outs_model > 0);
            if (mon_hs) begin
                got_q.push_back({req.addr, req.alen});
                end_off = int'(req.addr[11:0]) + (int'(req.alen) + 1) * 4;
                chk("no_4k_cross", 64'(end_off <= 4096), 64'd1);
                chk("alen_cap", 64'(req.alen <= max_alen), 64'd1);
            end
            outs_model = outs_model + int'(mon_hs) - int'(mon_fin);
            if (mon_hs) chk("outstanding_cap", 64'(outs_model <= MAXO), 64'd1);
            pend      = req.valid && !resp.ready;
            pend_addr = req.addr;
            pend_alen = req.alen;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: split the descriptor with plain arithmetic.
    function automatic void model_bursts(input logic [31:0] a0, input logic [31:0] bytes,
                                         input logic [7:0] ma);
        longint a    = longint'(a0);
        longint left = longint'(bytes) / 4;
        longint page, n;
        exp_q.delete();
        while (left > 0) begin
            page = (4096 - (a % 4096)) / 4;
            n = left;
            if (longint'(ma) + 1 < n) n = longint'(ma) + 1;
            if (page < n) n = page;
            exp_q.push_back({32'(a), 8'(n - 1)});
            a    = a + 4 * n;
            left = left - n;
        end
    endfunction

    task automatic cmp_bursts(input logic [31:0] a, input logic [31:0] b, input logic [7:0] m);
        int n;
        model_bursts(a, b, m);
        chk("burst_count", 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk("burst_addr", 64'(got_q[i].addr), 64'(exp_q[i].addr));
            chk("burst_alen", 64'(got_q[i].alen), 64'(exp_q[i].alen));
        end
    endtask

    task automatic start_desc(input logic [31:0] a, input logic [31:0] b, input logic [7:0] m);
        got_q.delete();
        done_cnt   = 0;
        cfg_cnt    = 0;
        desc_addr  = a;
        desc_bytes = b;
        max_alen   = m;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic run_to_done(input bit rnd, input int bound);
        int cyc = 0;
        while (done_cnt == 0 && cyc < bound) begin
            resp.ready  = rnd ? ($urandom % 4 != 0) : 1'b1;
            resp.finish = (outs_model > 0) && (rnd ? ($urandom % 2 == 1) : 1'b1);
            tick();
            cyc++;
        end
        resp = '0;
        chk("done_pulse", 64'(done_cnt), 64'd1);
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb;
        logic [7:0]  rm;

        tbl[0] = '{32'h0000_1000, 32'd64,   8'd15,  1'b0, 1};
        tbl[1] = '{32'h0000_0FF0, 32'd64,   8'd255, 1'b0, 2};
        tbl[2] = '{32'h0000_3002, 32'd64,   8'd15,  1'b1, 0};
        tbl[3] = '{32'h0000_1000, 32'd0,    8'd15,  1'b1, 0};
        tbl[4] = '{32'h0000_1000, 32'd6,    8'd15,  1'b1, 0};
        tbl[5] = '{32'h0000_2000, 32'd4096, 8'd255, 1'b0, 4};
        tbl[6] = '{32'h0000_2FFC, 32'd8,    8'd255, 1'b0, 2};
        tbl[7] = '{32'h0000_0000, 32'd40,   8'd1,   1'b0, 5};
        tbl[8] = '{32'h0000_7F00, 32'd1024, 8'd255, 1'b0, 2};

        rstn = 1'b0; dma_active = 1'b0; start = 1'b0;
        desc_addr = '0; desc_bytes = '0; max_alen = '0; resp = '0;
        tick(); tick();
        chk("rst_valid", 64'(req.valid), 64'd0);
        chk("rst_addr",  64'(req.addr),  64'd0);
        chk("rst_alen",  64'(req.alen),  64'd0);
        chk("rst_size",  64'(req.size),  64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_done",  64'(done),      64'd0);
        chk("rst_cfgerr", 64'(cfg_err),  64'd0);
        rstn = 1'b1; dma_active = 1'b1;
        tick();

        // Descriptor table.
        foreach (tbl[i]) begin
            start_desc(tbl[i].addr, tbl[i].bytes, tbl[i].max_alen);
            if (tbl[i].exp_err) begin
                chk("err_pulse",   64'(cfg_err),   64'd1);
                chk("err_busy",    64'(busy),      64'd0);
                chk("err_valid",   64'(req.valid), 64'd0);
                tick();
                chk("err_pulse_end", 64'(cfg_err), 64'd0);
                chk("err_busy2",   64'(busy),      64'd0);
                tick();
                chk("err_count",   64'(cfg_cnt),   64'd1);
                chk("err_bursts",  64'(got_q.size()), 64'd0);
            end else begin
                run_to_done(1'b0, 2000);
                chk("tbl_bursts", 64'(got_q.size()), 64'(tbl[i].exp_n));
                cmp_bursts(tbl[i].addr, tbl[i].bytes, tbl[i].max_alen);
                chk("tbl_no_err", 64'(cfg_cnt), 64'd0);
            end
            tick();
        end

        // Single burst: first valid one cycle after start, done two cycles after finish.
        resp.ready = 1'b1;
        start_desc(32'h1000, 32'd64, 8'd15);
        chk("first_valid", 64'(req.valid), 64'd1);
        chk("first_addr",  64'(req.addr),  64'h1000);
        chk("first_alen",  64'(req.alen),  64'd15);
        chk("first_size",  64'(req.size),  64'd2);
        chk("first_busy",  64'(busy),      64'd1);
        tick();
        resp.ready = 1'b0;
        chk("drain_valid", 64'(req.valid), 64'd0);
        resp.finish = 1'b1;
        tick();
        resp.finish = 1'b0;
        chk("drain_done0", 64'(done), 64'd0);
        chk("drain_busy",  64'(busy), 64'd1);
        tick();
        chk("done_high",   64'(done), 64'd1);
        chk("done_busy",   64'(busy), 64'd0);
        tick();
        chk("done_low",    64'(done), 64'd0);

        // Outstanding limit: 8 bursts then stall; one finish releases the 9th.
        resp.ready = 1'b1;
        start_desc(32'h2000, 32'd4096, 8'd7);
        repeat (12) tick();
        chk("limit_bursts", 64'(got_q.size()), 64'd8);
        chk("limit_valid",  64'(req.valid),    64'd0);
        resp.finish = 1'b1;
        tick();
        resp.finish = 1'b0;
        chk("limit_reissue", 64'(req.valid), 64'd1);
        chk("limit_addr9",   64'(req.addr),  64'h2100);
        chk("limit_alen9",   64'(req.alen),  64'd7);
        tick();
        chk("limit_bursts9", 64'(got_q.size()), 64'd9);
        chk("limit_valid2",  64'(req.valid),    64'd0);
        resp.ready = 1'b0; dma_active = 1'b0;
        tick();
        dma_active = 1'b1;
        chk("limit_abort_busy", 64'(busy), 64'd0);
        tick();

        // Stall for 5 cycles, then a handshake coinciding with a finish.
        resp = '0;
        start_desc(32'h1000, 32'd64, 8'd3);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(req.valid), 64'd1);
            chk("stall_addr",  64'(req.addr),  64'h1000);
            chk("stall_alen",  64'(req.alen),  64'd3);
            tick();
        end
        resp.ready = 1'b1;
        tick();
        resp.finish = 1'b1;
        tick();
        resp.finish = 1'b0;
        tick(); tick();
        resp.ready = 1'b0;
        chk("sim_bursts", 64'(got_q.size()), 64'd4);
        resp.finish = 1'b1;
        tick(); tick();
        resp.finish = 1'b0;
        tick(); tick();
        chk("sim_no_done_yet", 64'(done_cnt), 64'd0);
        chk("sim_busy",        64'(busy),     64'd1);
        resp.finish = 1'b1;
        tick();
        resp.finish = 1'b0;
        tick(); tick(); tick();
        chk("sim_done", 64'(done_cnt), 64'd1);
        cmp_bursts(32'h1000, 32'd64, 8'd3);

        // Abort with 3 outstanding, then a clean restart.
        resp.ready = 1'b1;
        start_desc(32'h4000, 32'd4096, 8'd3);
        tick(); tick(); tick();
        chk("abort_outs", 64'(got_q.size()), 64'd3);
        resp.ready = 1'b0; dma_active = 1'b0;
        tick();
        chk("abort_valid", 64'(req.valid), 64'd0);
        chk("abort_busy",  64'(busy),      64'd0);
        dma_active = 1'b1;
        tick(); tick(); tick();
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        start_desc(32'h1000, 32'd64, 8'd15);
        chk("restart_valid", 64'(req.valid), 64'd1);
        chk("restart_addr",  64'(req.addr),  64'h1000);
        run_to_done(1'b0, 200);
        cmp_bursts(32'h1000, 32'd64, 8'd15);
        tick();

        // Reset mid-burst discards state without done.
        resp.ready = 1'b1;
        start_desc(32'h5000, 32'd256, 8'd3);
        tick(); tick();
        resp.ready = 1'b0; rstn = 1'b0;
        tick();
        chk("mrst_valid", 64'(req.valid), 64'd0);
        chk("mrst_addr",  64'(req.addr),  64'd0);
        chk("mrst_busy",  64'(busy),      64'd0);
        rstn = 1'b1;
        tick(); tick(); tick();
        chk("mrst_no_done", 64'(done_cnt), 64'd0);

        // Random descriptors with random ready/finish.
        for (int t = 0; t < 25; t++) begin
            ra = {16'h0, 4'($urandom), 10'($urandom), 2'b00};
            if (t % 3 == 0) ra = {16'h0, 4'($urandom), 12'hFF0 - 12'(4 * $urandom_range(0, 3))};
            rb = 32'(4 * $urandom_range(1, 200));
            case ($urandom % 4)
                0:       rm = 8'd255;
                1:       rm = 8'($urandom % 16);
                2:       rm = 8'($urandom);
                default: rm = 8'd0;
            endcase
            start_desc(ra, rb, rm);
            run_to_done(1'b1, 20000);
            cmp_bursts(ra, rb, rm);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
